// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch stage: one instruction in flight over a req/valid memory handshake,
// with the held instruction and its decoded fields presented until downstream consumes it.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StErr} state_e;

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      wait_q  <= 8'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        wait_d  = 8'h0;
        state_d = StFetch;
      end
      StFetch: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          wait_d  = 8'h0;
          state_d = StHold;
        end else if (wait_q == WaitLast) begin
          err_d   = 1'b1;
          state_d = StErr;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StHold: begin
        if (instr_ready) begin
          // A misaligned redirect is fatal and leaves pc pointing at the held instruction.
          if (PCSrc && (branch_target[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = StErr;
          end else begin
            pc_d    = PCSrc ? branch_target : pc_q + 32'd4;
            state_d = StFetch;
          end
        end
      end
      StErr: state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StHold);
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign rd          = instr_q[11:7];
  assign func3       = instr_q[14:12];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];
  assign func7       = instr_q[31:25];
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized fetch/stall/redirect
// traffic checked against a lazily-filled memory and an arithmetic next-pc model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RstPc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, instr_valid, fetch_err;
  logic [31:0] imem_addr, pc_out, instr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic        instr_ready = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [4:0]  rd, rs1, rs2;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] exp_pc;
  logic [31:0] cur_word;
  logic [31:0] mem [logic [31:0]];

  instr_fetch_unit #(.RESET_PC(RstPc), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCSrc(PCSrc), .branch_target(branch_target), .pc_out(pc_out), .instr(instr),
    .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_word(input logic [31:0] addr, output logic [31:0] w);
    if (!mem.exists(addr)) mem[addr] = $urandom;
    w = mem[addr];
  endtask

  // Checks every output against its reset value.
  task automatic check_reset_values(input string tag);
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_ctrl got req=%b valid=%b err=%b want 0 0 0", tag, imem_req, instr_valid,
               fetch_err);
    end
    n_checks++;
    if (imem_addr !== RstPc || pc_out !== RstPc) begin
      n_fail++;
      $display("FAIL %s_pc got addr=%h pc_out=%h want %h", tag, imem_addr, pc_out, RstPc);
    end
    n_checks++;
    if (instr !== 32'h0 || opcode !== 7'h0 || func3 !== 3'h0 || func7 !== 7'h0 ||
        rd !== 5'h0 || rs1 !== 5'h0 || rs2 !== 5'h0) begin
      n_fail++;
      $display("FAIL %s_instr got instr=%h fields=%h/%h/%h/%h/%h/%h want all 0", tag, instr,
               opcode, func3, func7, rd, rs1, rs2);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = RstPc;
    tick();
  endtask

  // Starts in a FETCH cycle; waits wait_n cycles, then returns data. Ends in HOLD.
  task automatic fetch_phase(input int wait_n);
    mem_word(exp_pc, cur_word);
    for (int i = 0; i <= wait_n; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_req cyc%0d got req=%b addr=%h ival=%b want 1 %h 0", i, imem_req,
                 imem_addr, instr_valid, exp_pc);
      end
      imem_valid    = (i == wait_n);
      imem_rdata    = (i == wait_n) ? cur_word : $urandom;
      instr_ready   = 1'($urandom);
      PCSrc         = 1'b1;
      branch_target = $urandom;
      tick();
    end
    imem_valid  = 1'b0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== cur_word || pc_out !== exp_pc) begin
      n_fail++;
      $display("FAIL hold_entry got ival=%b req=%b instr=%h pc=%h want 1 0 %h %h", instr_valid,
               imem_req, instr, pc_out, cur_word, exp_pc);
    end
    n_checks++;
    if (opcode !== cur_word[6:0] || rd !== cur_word[11:7] || func3 !== cur_word[14:12] ||
        rs1 !== cur_word[19:15] || rs2 !== cur_word[24:20] || func7 !== cur_word[31:25]) begin
      n_fail++;
      $display("FAIL fields got %h/%h/%h/%h/%h/%h for instr %h", opcode, rd, func3, rs1, rs2,
               func7, cur_word);
    end
  endtask

  // Stalls stall_n cycles in HOLD with noise on ignored inputs, then consumes.
  task automatic consume_phase(input int stall_n, input logic take, input logic [31:0] tgt);
    for (int j = 0; j < stall_n; j++) begin
      instr_ready   = 1'b0;
      imem_valid    = 1'($urandom);
      imem_rdata    = $urandom;
      PCSrc         = 1'($urandom);
      branch_target = $urandom;
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== cur_word || pc_out !== exp_pc) begin
        n_fail++;
        $display("FAIL stall cyc%0d got ival=%b req=%b instr=%h pc=%h want 1 0 %h %h", j,
                 instr_valid, imem_req, instr, pc_out, cur_word, exp_pc);
      end
    end
    imem_valid    = 1'b0;
    instr_ready   = 1'b1;
    PCSrc         = take;
    branch_target = tgt;
    tick();
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    if (take && tgt[1:0] != 2'b00) begin
      n_checks++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          imem_addr !== exp_pc) begin
        n_fail++;
        $display("FAIL misalign got err=%b req=%b ival=%b addr=%h want 1 0 0 %h", fetch_err,
                 imem_req, instr_valid, imem_addr, exp_pc);
      end
    end else begin
      exp_pc = take ? tgt : exp_pc + 32'd4;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc_out !== exp_pc ||
          instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
        n_fail++;
        $display("FAIL consume got req=%b addr=%h pc=%h ival=%b err=%b want 1 %h %h 0 0",
                 imem_req, imem_addr, pc_out, instr_valid, fetch_err, exp_pc, exp_pc);
      end
    end
  endtask

  // ERR must hold through arbitrary input activity.
  task automatic check_err_sticky(input string tag);
    for (int k = 0; k < 5; k++) begin
      imem_valid  = 1'b1;
      imem_rdata  = $urandom;
      instr_ready = 1'b1;
      tick();
      n_checks++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_sticky cyc%0d got err=%b req=%b ival=%b want 1 0 0", tag, k, fetch_err,
                 imem_req, instr_valid);
      end
    end
    imem_valid  = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    check_reset_values("reset_held");
    rst = 1'b0;
    exp_pc = RstPc;
    check_reset_values("reset_idle");
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RstPc) begin
      n_fail++;
      $display("FAIL first_fetch got req=%b addr=%h want 1 %h", imem_req, imem_addr, RstPc);
    end
  endtask

  task automatic test_zero_wait();
    mem[32'h100] = 32'h00A30333;
    fetch_phase(0);
    n_checks++;
    if (opcode !== 7'h33 || func3 !== 3'd0 || func7 !== 7'd0 || rd !== 5'd6 || rs1 !== 5'd6 ||
        rs2 !== 5'd10) begin
      n_fail++;
      $display("FAIL add_decode got op=%h f3=%h f7=%h rd=%0d rs1=%0d rs2=%0d want 33 0 0 6 6 10",
               opcode, func3, func7, rd, rs1, rs2);
    end
    consume_phase(0, 1'b0, 32'h0);
    fetch_phase(0);
    consume_phase(0, 1'b0, 32'h0);
    n_checks++;
    if (imem_addr !== 32'h108) begin
      n_fail++;
      $display("FAIL seq_addr got %h want 00000108", imem_addr);
    end
    fetch_phase(0);
    consume_phase(0, 1'b0, 32'h0);
  endtask

  task automatic test_wait_states();
    fetch_phase(3);
    consume_phase(0, 1'b0, 32'h0);
  endtask

  task automatic test_stall();
    fetch_phase(0);
    consume_phase(5, 1'b0, 32'h0);
  endtask

  task automatic test_branch_and_wrap();
    fetch_phase(0);
    consume_phase(0, 1'b1, 32'h200);
    fetch_phase(1);
    consume_phase(0, 1'b1, 32'hFFFF_FFFC);
    fetch_phase(0);
    consume_phase(0, 1'b0, 32'h0);
    fetch_phase(2);
    consume_phase(1, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      fetch_phase(int'($urandom_range(0, 3)));
      consume_phase(int'($urandom_range(0, 3)), 1'($urandom), {$urandom_range(0, 32'h3FFF), 2'b00});
    end
  endtask

  task automatic test_misaligned();
    fetch_phase(0);
    consume_phase(0, 1'b1, 32'h200);
    fetch_phase(0);
    consume_phase(0, 1'b1, 32'h202);
    check_err_sticky("misalign");
    do_reset();
  endtask

  task automatic test_timeout();
    for (int c = 1; c <= 4; c++) begin
      imem_valid = 1'b0;
      tick();
      n_checks++;
      if (fetch_err !== (c == 4) || imem_req !== (c != 4)) begin
        n_fail++;
        $display("FAIL timeout cyc%0d got err=%b req=%b want %b %b", c, fetch_err, imem_req,
                 c == 4, c != 4);
      end
    end
    check_err_sticky("timeout");
    do_reset();
  endtask

  task automatic test_reset_mid_fetch();
    fetch_phase(0);
    consume_phase(0, 1'b0, 32'h0);
    imem_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid_fetch");
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    exp_pc = RstPc;
    tick();
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RstPc || instr !== 32'h0) begin
      n_fail++;
      $display("FAIL late_valid got ival=%b req=%b addr=%h instr=%h want 0 1 %h 0", instr_valid,
               imem_req, imem_addr, instr, RstPc);
    end
    imem_valid = 1'b0;
    fetch_phase(0);
    consume_phase(0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch_and_wrap();
    test_random();
    test_misaligned();
    test_timeout();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the RV32I core. Holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a request/valid handshake, and presents the registered instruction and its decoded fields (opcode, func3, func7, register indices) to the control unit and register file. Next-PC selection uses the control unit's PCSrc and the branch target computed downstream, applied when the current instruction is consumed.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT, 16, max FETCH-state cycles waiting for imem_valid before a fetch error; 1..255.
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  fetch address (= pc).
- imem_rdata  in  32  instruction word, sampled when imem_valid.
- imem_valid  in  1  memory returns data; may assert in the same cycle as imem_req.
- instr_valid  out  1  instruction register holds a valid instruction.
- instr_ready  in  1  downstream consumes the current instruction.
- PCSrc  in  1  take branch_target (sampled on consume only).
- branch_target  in  32  redirect address.
- pc_out  out  32  address of the held instruction.
- instr  out  32  held instruction.
- opcode  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- rd, rs1, rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20].
- fetch_err  out  1  sticky error flag.

## Operation
- States: IDLE, FETCH, HOLD, ERR.
- IDLE: entered on reset; unconditionally to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_valid. On imem_valid: instr<=imem_rdata, go HOLD, clear wait counter. Otherwise wait counter increments; when counter reaches TIMEOUT-1 with no imem_valid, set fetch_err, go ERR.
- HOLD: imem_req=0, instr_valid=1, instr/pc_out stable. On instr_ready: pc <= PCSrc ? branch_target : pc+4; go FETCH. Without instr_ready: stay HOLD indefinitely (stall).
- Misaligned redirect: on consume with PCSrc=1 and branch_target[1:0]!=0, set fetch_err, go ERR; pc unchanged.
- ERR: imem_req=0, instr_valid=0; held until rst.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no error.
- imem_valid outside FETCH is ignored; instr_ready outside HOLD is ignored; PCSrc/branch_target ignored except on consume.
- Decoded fields are pure slices of the instr register (no extra latency).

## Timing
- Reset (async, immediate): state=IDLE, pc=RESET_PC, instr=0, all field outputs 0, pc_out=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, fetch_err=0, wait counter=0.
- First rising edge after rst deasserts: IDLE->FETCH; imem_req high from that cycle.
- Zero-wait memory (imem_valid in first FETCH cycle): instr_valid rises the following cycle; peak throughput one instruction per 2 cycles with instr_ready held high.
- N wait cycles add N cycles of latency.
- Consume edge: pc_out updates and instr_valid drops in the same cycle FETCH begins with the new address.
- rst during FETCH or HOLD aborts immediately; any outstanding memory response is discarded (imem_valid in IDLE ignored).

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory, instr_ready=1 -> imem_addr sequence 0x100,0x104,0x108; instr_valid every other cycle; opcode/func3/func7 match each word (e.g. 0x00A30333 -> opcode 0x33, func3 0, func7 0, rd 6, rs1 6, rs2 10).
- Memory with 3 wait cycles -> imem_req/imem_addr stable 4 cycles; instr_valid rises cycle after imem_valid.
- instr_ready low 5 cycles in HOLD -> instr and pc_out unchanged, imem_req=0; on ready, next fetch at pc+4.
- Consume with PCSrc=1, branch_target=0x200 -> next imem_addr=0x200; with branch_target=0x202 -> fetch_err=1, ERR, no further requests until rst.
- TIMEOUT=4, imem_valid never asserted -> fetch_err set after 4 FETCH cycles; imem_req drops.
- pc=32'hFFFF_FFFC consumed with PCSrc=0 -> next imem_addr=0; rst asserted mid-FETCH -> outputs at reset values same cycle, late imem_valid ignored.
